// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM encodings and
// default halt/boot constants.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BOOT     = 3'd1,
        ST_FETCH    = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_HALTED   = 3'd4
    } fetch_state_e;

    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
    localparam logic [31:0] BOOT_ADDR_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_controller_if.sv
// Bundle between the fetch controller, the Fetch datapath and the decode stage.
// master = controller side, slave = datapath/decode side.
interface fetch_controller_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
);
    logic               start;
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  pc_current;
    logic [ADDR_W-1:0]  pc_next;
    logic               br_taken;
    logic [ADDR_W-1:0]  br_target;
    logic               id_ready;

    logic               pc_write_en;
    logic               pc_load;
    logic [ADDR_W-1:0]  pc_load_addr;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
    logic [ADDR_W-1:0]  if_pc_next;
    logic               halted;
    logic [CNT_W-1:0]   fetch_count;

    modport master (
        input  start, instruction, pc_current, pc_next, br_taken, br_target, id_ready,
        output pc_write_en, pc_load, pc_load_addr, if_valid, if_instr, if_pc,
               if_pc_next, halted, fetch_count
    );

    modport slave (
        output start, instruction, pc_current, pc_next, br_taken, br_target, id_ready,
        input  pc_write_en, pc_load, pc_load_addr, if_valid, if_instr, if_pc,
               if_pc_next, halted, fetch_count
    );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: flush > capture > drain (consumer took it) > hold.
module if_id_reg #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               capture,
    input  logic               drain,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [ADDR_W-1:0]  d_pc,
    input  logic [ADDR_W-1:0]  d_pc_next,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_next
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= 1'b0;
            instr   <= '0;
            pc      <= '0;
            pc_next <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid   <= 1'b1;
            instr   <= d_instr;
            pc      <= d_pc;
            pc_next <= d_pc_next;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: drives PC write/load, fills the IF/ID register,
// handles branch redirect, decode back-pressure and halt.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter int                 CNT_W     = 16,
    parameter logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(HALT_WORD_DEF),
    parameter logic [ADDR_W-1:0]  BOOT_ADDR = ADDR_W'(BOOT_ADDR_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    fetch_controller_if.master bus
);

    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] tgt_q, tgt_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic              capture, flush, advance, valid;
    logic              pc_write_en, pc_load, halted;
    logic [ADDR_W-1:0] pc_load_addr;

    assign advance = !valid || bus.id_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            tgt_q <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            tgt_q <= tgt_nxt;
            if (capture && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        tgt_nxt      = tgt_q;
        capture      = 1'b0;
        flush        = 1'b0;
        pc_write_en  = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = '0;
        halted       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start)
                    state_nxt = ST_BOOT;
            end
            ST_BOOT: begin
                pc_write_en  = 1'b1;
                pc_load      = 1'b1;
                pc_load_addr = BOOT_ADDR;
                state_nxt    = ST_FETCH;
            end
            ST_FETCH: begin
                // A redirect outranks back-pressure: the held entry is wrong-path anyway.
                if (bus.br_taken) begin
                    flush     = 1'b1;
                    tgt_nxt   = bus.br_target;
                    state_nxt = ST_REDIRECT;
                end else if (advance) begin
                    pc_write_en = 1'b1;
                    capture     = 1'b1;
                    if (bus.instruction == HALT_WORD)
                        state_nxt = ST_HALTED;
                end
            end
            ST_REDIRECT: begin
                pc_write_en  = 1'b1;
                pc_load      = 1'b1;
                pc_load_addr = tgt_q;
                if (bus.br_taken)
                    tgt_nxt = bus.br_target;
                else
                    state_nxt = ST_FETCH;
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .capture   (capture),
        .drain     (bus.id_ready),
        .d_instr   (bus.instruction),
        .d_pc      (bus.pc_current),
        .d_pc_next (bus.pc_next),
        .valid     (valid),
        .instr     (bus.if_instr),
        .pc        (bus.if_pc),
        .pc_next   (bus.if_pc_next)
    );

    assign bus.if_valid     = valid;
    assign bus.pc_write_en  = pc_write_en;
    assign bus.pc_load      = pc_load;
    assign bus.pc_load_addr = pc_load_addr;
    assign bus.halted       = halted;
    assign bus.fetch_count  = cnt_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: models the Fetch datapath (PC + combinational IM) and
// scoreboards every IF/ID word the decode side accepts.
module tb_fetch_controller;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, id_ready, br_taken;
    logic [31:0] br_target;
    logic [31:0] pc_q;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    fetch_controller_if #(.ADDR_W(32), .INSTR_W(32), .CNT_W(16)) bus  ();
    fetch_controller_if #(.ADDR_W(32), .INSTR_W(32), .CNT_W(2))  bus2 ();

    fetch_controller #(.ADDR_W(32), .INSTR_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    fetch_controller #(.ADDR_W(32), .INSTR_W(32), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .bus(bus2));

    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0000_000C) return HALT;
        return 32'h1234_0000 ^ a;
    endfunction

    // Fetch datapath model; both controllers see the same stimulus.
    always_ff @(posedge clk) begin
        if (reset)
            pc_q <= '0;
        else if (bus.pc_write_en)
            pc_q <= bus.pc_load ? bus.pc_load_addr : pc_q + 32'd4;
    end

    assign bus.start        = start;
    assign bus.id_ready     = id_ready;
    assign bus.br_taken     = br_taken;
    assign bus.br_target    = br_target;
    assign bus.pc_current   = pc_q;
    assign bus.pc_next      = pc_q + 32'd4;
    assign bus.instruction  = imem(pc_q);
    assign bus2.start       = start;
    assign bus2.id_ready    = id_ready;
    assign bus2.br_taken    = br_taken;
    assign bus2.br_target   = br_target;
    assign bus2.pc_current  = pc_q;
    assign bus2.pc_next     = pc_q + 32'd4;
    assign bus2.instruction = imem(pc_q);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Settle inputs, score any handshake taking place at the next edge, then step past it.
    task automatic cycle();
        logic [31:0] e;
        #1;
        chk("load_implies_we", {63'd0, bus.pc_load & ~bus.pc_write_en}, 64'd0);
        if (bus.if_valid && id_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_pc", {32'd0, bus.if_pc}, 64'hDEAD);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pc",      {32'd0, bus.if_pc},      {32'd0, e});
                chk("sb_instr",   {32'd0, bus.if_instr},   {32'd0, imem(e)});
                chk("sb_pc_next", {32'd0, bus.if_pc_next}, {32'd0, e + 32'd4});
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    {63'd0, bus.pc_write_en}, 64'd0);
        chk({tag, "_load"},  {63'd0, bus.pc_load},     64'd0);
        chk({tag, "_laddr"}, {32'd0, bus.pc_load_addr}, 64'd0);
        chk({tag, "_valid"}, {63'd0, bus.if_valid},    64'd0);
        chk({tag, "_instr"}, {32'd0, bus.if_instr},    64'd0);
        chk({tag, "_pc"},    {32'd0, bus.if_pc},       64'd0);
        chk({tag, "_pcn"},   {32'd0, bus.if_pc_next},  64'd0);
        chk({tag, "_halt"},  {63'd0, bus.halted},      64'd0);
        chk({tag, "_cnt"},   {48'd0, bus.fetch_count}, 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; id_ready = 1'b0; br_taken = 1'b0; br_target = '0;
        cycle(); cycle();
        chk_all_zero("reset");
        reset = 1'b0;
        cycle();
        chk_all_zero("idle");

        // boot and three straight-line fetches
        sb_q.push_back(32'h0); sb_q.push_back(32'h4);
        start = 1'b1; id_ready = 1'b1;
        cycle();
        start = 1'b0;
        chk("boot_load", {63'd0, bus.pc_load}, 64'd1);
        chk("boot_we",   {63'd0, bus.pc_write_en}, 64'd1);
        chk("boot_addr", {32'd0, bus.pc_load_addr}, 64'd0);
        cycle();
        chk("fetch_load", {63'd0, bus.pc_load}, 64'd0);
        chk("fetch_valid0", {63'd0, bus.if_valid}, 64'd0);
        cycle();
        chk("first_valid", {63'd0, bus.if_valid}, 64'd1);
        chk("first_pc", {32'd0, bus.if_pc}, 64'd0);
        cycle(); cycle();
        chk("pc_8", {32'd0, bus.if_pc}, 64'h8);
        chk("count_3", {48'd0, bus.fetch_count}, 64'd3);
        chk("sat_count_3", {62'd0, bus2.fetch_count}, 64'd3);

        // back-pressure with a valid entry
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_we", {63'd0, bus.pc_write_en}, 64'd0);
            cycle();
            chk("stall_pc", {32'd0, bus.if_pc}, 64'h8);
            chk("stall_instr", {32'd0, bus.if_instr}, {32'd0, imem(32'h8)});
        end

        // redirect while stalled at 0x8
        br_taken = 1'b1; br_target = 32'h40;
        cycle();
        br_taken = 1'b0;
        chk("redir_flush", {63'd0, bus.if_valid}, 64'd0);
        chk("redir_load", {63'd0, bus.pc_load}, 64'd1);
        chk("redir_we", {63'd0, bus.pc_write_en}, 64'd1);
        chk("redir_addr", {32'd0, bus.pc_load_addr}, 64'h40);
        chk("redir_count", {48'd0, bus.fetch_count}, 64'd3);
        sb_q.push_back(32'h40); sb_q.push_back(32'h44);
        id_ready = 1'b1;
        cycle();
        chk("post_redir_valid", {63'd0, bus.if_valid}, 64'd0);
        cycle();
        chk("target_pc", {32'd0, bus.if_pc}, 64'h40);
        chk("count_4", {48'd0, bus.fetch_count}, 64'd4);
        chk("sat_hold", {62'd0, bus2.fetch_count}, 64'd3);
        cycle();
        chk("pc_44", {32'd0, bus.if_pc}, 64'h44);

        // stall, then release continues at pc+4
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall2_we", {63'd0, bus.pc_write_en}, 64'd0);
            cycle();
            chk("stall2_pc", {32'd0, bus.if_pc}, 64'h44);
        end
        id_ready = 1'b1;
        cycle();
        chk("release_pc", {32'd0, bus.if_pc}, 64'h48);
        chk("count_6", {48'd0, bus.fetch_count}, 64'd6);

        // back-to-back redirects: second target replaces the first
        id_ready = 1'b0; br_taken = 1'b1; br_target = 32'h20;
        cycle();
        chk("redir1_addr", {32'd0, bus.pc_load_addr}, 64'h20);
        br_target = 32'hC;
        cycle();
        br_taken = 1'b0;
        chk("redir2_load", {63'd0, bus.pc_load}, 64'd1);
        chk("redir2_addr", {32'd0, bus.pc_load_addr}, 64'hC);
        cycle();
        chk("redir2_done", {63'd0, bus.pc_load}, 64'd0);
        chk("count_still_6", {48'd0, bus.fetch_count}, 64'd6);

        // halt word at 0xC
        sb_q.push_back(32'hC);
        cycle();
        chk("halt_valid", {63'd0, bus.if_valid}, 64'd1);
        chk("halt_instr", {32'd0, bus.if_instr}, {32'd0, HALT});
        chk("halted", {63'd0, bus.halted}, 64'd1);
        chk("halt_we", {63'd0, bus.pc_write_en}, 64'd0);
        chk("count_7", {48'd0, bus.fetch_count}, 64'd7);
        br_taken = 1'b1; br_target = 32'h40;
        cycle();
        chk("halt_br_load", {63'd0, bus.pc_load}, 64'd0);
        chk("halt_br_we", {63'd0, bus.pc_write_en}, 64'd0);
        chk("halt_br_valid", {63'd0, bus.if_valid}, 64'd1);
        br_taken = 1'b0; id_ready = 1'b1;
        cycle();
        chk("halt_drain", {63'd0, bus.if_valid}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("halt_stays", {63'd0, bus.halted}, 64'd1);
            chk("halt_we_off", {63'd0, bus.pc_write_en}, 64'd0);
        end
        chk("sat_final", {62'd0, bus2.fetch_count}, 64'd3);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        // reset in the middle of FETCH with a valid entry
        reset = 1'b1; cycle(); reset = 1'b0;
        id_ready = 1'b0; start = 1'b1;
        cycle(); start = 1'b0;
        cycle(); cycle();
        chk("mid_valid", {63'd0, bus.if_valid}, 64'd1);
        chk("mid_fetch_pc", {32'd0, bus.if_pc}, 64'd0);
        sb_q.push_back(32'h0);
        id_ready = 1'b1;
        #1;
        chk("mid_we", {63'd0, bus.pc_write_en}, 64'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        id_ready = 1'b0;
        chk_all_zero("midreset");
        chk("midreset_sat", {62'd0, bus2.fetch_count}, 64'd0);
        cycle(); cycle();
        chk_all_zero("idle_after");
        chk("sb_empty_end", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
